// File: rtl/scroll_ctrl.sv
// Per-frame scroll and lane controller: drives shared hoffset/voffset for all layers.
// Optional distance accumulator enabled by defining SCROLL_DISTANCE_EN.
module scroll_ctrl #(
    parameter int unsigned HWIDTH      = 12,
    parameter int unsigned VWIDTH      = 12,
    parameter int unsigned VSIZE       = 480,
    parameter int unsigned SWIDTH      = 5,
    parameter int unsigned SPEED_INIT  = 1,
    parameter int unsigned SPEED_MAX   = 16,
    parameter int unsigned RAMP_FRAMES = 256,
    parameter int unsigned LANE_W      = 64,
    parameter int unsigned HSLEW       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              start,
    input  logic              pause,
    input  logic              crash,
    input  logic              left,
    input  logic              right,
    output logic [HWIDTH-1:0] hoffset,
    output logic [VWIDTH-1:0] voffset,
    output logic [SWIDTH-1:0] speed,
    output logic [1:0]        state,
    output logic [15:0]       distance
);

    localparam int unsigned FCW  = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
    localparam int unsigned DW   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_CRASH = 2'b11
    } state_e;

    state_e            state_q,   state_d;
    logic [VWIDTH-1:0] voffset_q, voffset_d;
    logic [HWIDTH-1:0] hoffset_q, hoffset_d;
    logic [SWIDTH-1:0] speed_q,   speed_d;
    logic [1:0]        lane_q,    lane_d;
    logic [FCW-1:0]    fcnt_q,    fcnt_d;

    logic [VWIDTH:0]   v_sum;
    logic [VWIDTH-1:0] v_wrap;
    logic [HWIDTH-1:0] h_target;
    logic [HWIDTH-1:0] h_gap;
    logic [HWIDTH-1:0] h_step;
    logic [HWIDTH-1:0] h_slew;
    logic [SWIDTH-1:0] speed_up;
    logic [SWIDTH-1:0] speed_dn;
    logic              adv_c;
    logic              dist_clr_c;

    // Vertical scroll with one conditional subtract; speed < VSIZE keeps this exact.
    always_comb begin
        v_sum  = {1'b0, voffset_q} + (VWIDTH+1)'(speed_q);
        v_wrap = (v_sum >= (VWIDTH+1)'(VSIZE))
               ? VWIDTH'(v_sum - (VWIDTH+1)'(VSIZE))
               : VWIDTH'(v_sum);
    end

    // Horizontal slew toward the lane centre, clamped so it never overshoots.
    always_comb begin
        h_target = HWIDTH'(32'(lane_q) * LANE_W);
        h_gap    = (h_target > hoffset_q) ? (h_target - hoffset_q) : (hoffset_q - h_target);
        h_step   = (h_gap > HWIDTH'(HSLEW)) ? HWIDTH'(HSLEW) : h_gap;
        h_slew   = (h_target > hoffset_q) ? (hoffset_q + h_step) : (hoffset_q - h_step);
    end

    always_comb begin
        speed_up = (speed_q >= SWIDTH'(SPEED_MAX)) ? SWIDTH'(SPEED_MAX) : (speed_q + SWIDTH'(1));
        speed_dn = (speed_q == '0) ? '0 : (speed_q - SWIDTH'(1));
    end

    assign adv_c      = frame_start && ((state_q == ST_RUN) || (state_q == ST_CRASH));
    assign dist_clr_c = (state_q == ST_IDLE) && start;

    // Next-state and frame-update logic, all keyed off the current state.
    always_comb begin
        state_d   = state_q;
        voffset_d = voffset_q;
        hoffset_d = hoffset_q;
        speed_d   = speed_q;
        lane_d    = lane_q;
        fcnt_d    = fcnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    fcnt_d  = '0;
                end
            end

            ST_RUN: begin
                if (frame_start) begin
                    voffset_d = v_wrap;
                    hoffset_d = h_slew;
                    if (fcnt_q == FCW'(RAMP_FRAMES - 1)) begin
                        fcnt_d  = '0;
                        speed_d = speed_up;
                    end else begin
                        fcnt_d  = fcnt_q + FCW'(1);
                    end
                end
                if (crash) begin
                    state_d = ST_CRASH;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end else if (left && !right) begin
                    if (lane_q != 2'd0) lane_d = lane_q - 2'd1;
                end else if (right && !left) begin
                    if (lane_q != 2'd2) lane_d = lane_q + 2'd1;
                end
            end

            ST_PAUSE: begin
                if (crash) begin
                    state_d = ST_CRASH;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end

            ST_CRASH: begin
                if (start && (speed_q == '0)) begin
                    state_d   = ST_IDLE;
                    voffset_d = '0;
                    hoffset_d = HWIDTH'(LANE_W);
                    lane_d    = 2'd1;
                    speed_d   = SWIDTH'(SPEED_INIT);
                    fcnt_d    = '0;
                end else if (frame_start) begin
                    voffset_d = v_wrap;
                    hoffset_d = h_slew;
                    speed_d   = speed_dn;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            voffset_q <= '0;
            hoffset_q <= HWIDTH'(LANE_W);
            speed_q   <= SWIDTH'(SPEED_INIT);
            lane_q    <= 2'd1;
            fcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            voffset_q <= voffset_d;
            hoffset_q <= hoffset_d;
            speed_q   <= speed_d;
            lane_q    <= lane_d;
            fcnt_q    <= fcnt_d;
        end
    end

`ifdef SCROLL_DISTANCE_EN
    logic [DW-1:0] dist_q, dist_d;
    logic [DW:0]   dist_sum;

    // Saturating odometer of scrolled pixels, using speed before this frame's update.
    always_comb begin
        dist_sum = {1'b0, dist_q} + (DW+1)'(speed_q);
        dist_d   = dist_q;
        if (dist_clr_c) begin
            dist_d = '0;
        end else if (adv_c) begin
            dist_d = dist_sum[DW] ? {DW{1'b1}} : dist_sum[DW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dist_q <= '0;
        end else begin
            dist_q <= dist_d;
        end
    end

    assign distance = dist_q;
`else
    logic unused_dist;
    assign unused_dist = adv_c ^ dist_clr_c;
    assign distance    = DW'(0);
`endif

    assign state   = state_q;
    assign voffset = voffset_q;
    assign hoffset = hoffset_q;
    assign speed   = speed_q;

endmodule
